// File: rtl/button_event_pkg.sv
// Shared types and constants for the button event classifier.
package button_event_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRESSED   = 3'd1,
      LONG_HELD = 3'd2,
      WAIT_GAP  = 3'd3,
      SECOND    = 3'd4
   } btn_state_t;

   localparam int PRESS_CNT_W = 8;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_event_edge_detect.sv
// Registered-history edge detector; prev clears to 0 so a level that is
// already high out of reset reads as a rise.
module edge_detect (
   input  logic clk_in,
   input  logic rst_in,
   input  logic level_in,
   output logic rise,
   output logic fall
);

   logic prev;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) prev <= 1'b0;
      else        prev <= level_in;
   end

   assign rise = level_in & ~prev;
   assign fall = ~level_in & prev;

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into short / long / double-click pulses,
// using one shared cycle counter for both hold and gap timing.
module button_event
   import button_event_pkg::*;
#(
   parameter int LONG_CYCLES = 50_000_000,
   parameter int GAP_CYCLES  = 25_000_000
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   clean_in,
   output logic                   short_out,
   output logic                   long_out,
   output logic                   double_out,
   output logic                   held_out,
   output logic [PRESS_CNT_W-1:0] press_count_out
);

   localparam int CNT_W = $clog2(max_int(LONG_CYCLES, GAP_CYCLES));
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

   btn_state_t       state;
   logic [CNT_W-1:0] count;
   logic             rise;
   logic             fall;

   edge_detect u_edge (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .level_in (clean_in),
      .rise     (rise),
      .fall     (fall)
   );

   // In every pressed state the previous sample was high, so fall is
   // exactly "clean_in low" there.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state           <= IDLE;
         count           <= '0;
         short_out       <= 1'b0;
         long_out        <= 1'b0;
         double_out      <= 1'b0;
         held_out        <= 1'b0;
         press_count_out <= '0;
      end else begin
         short_out  <= 1'b0;
         long_out   <= 1'b0;
         double_out <= 1'b0;
         if (rise) press_count_out <= press_count_out + 1'b1;

         case (state)
            IDLE: begin
               if (rise) begin
                  state    <= PRESSED;
                  count    <= '0;
                  held_out <= 1'b1;
               end
            end
            PRESSED: begin
               if (fall) begin
                  state    <= WAIT_GAP;
                  count    <= '0;
                  held_out <= 1'b0;
               end else if (count == LONG_LAST) begin
                  state    <= LONG_HELD;
                  count    <= '0;
                  long_out <= 1'b1;
               end else begin
                  count <= count + 1'b1;
               end
            end
            LONG_HELD: begin
               if (fall) begin
                  state    <= IDLE;
                  count    <= '0;
                  held_out <= 1'b0;
               end
            end
            WAIT_GAP: begin
               // A repress on the final gap cycle still counts as a double click.
               if (rise) begin
                  state      <= SECOND;
                  count      <= '0;
                  double_out <= 1'b1;
                  held_out   <= 1'b1;
               end else if (count == GAP_LAST) begin
                  state     <= IDLE;
                  count     <= '0;
                  short_out <= 1'b1;
               end else begin
                  count <= count + 1'b1;
               end
            end
            SECOND: begin
               if (fall) begin
                  state    <= IDLE;
                  count    <= '0;
                  held_out <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               count    <= '0;
               held_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/button_event.md
# button_event

Classifies presses of a single debounced, clk_in-synchronous button level into one-cycle event pulses: short press, long press and double click. It sits directly downstream of the debouncer, takes its clean output as `clean_in`, and feeds the user-logic / display layer. Press timing is set in clock cycles; defaults assume a 100 MHz clk_in.

## Interface
- `LONG_CYCLES`, default 50_000_000: hold duration that qualifies as a long press (500 ms); minimum 2.
- `GAP_CYCLES`, default 25_000_000: maximum release-to-repress gap for a double click (250 ms); minimum 2.
- Reset `rst_in` is asynchronous and active-high; clock is `clk_in`.
- `clk_in` in 1: system clock.
- `rst_in` in 1: asynchronous, active-high reset.
- `clean_in` in 1: debounced button level, already synchronous to `clk_in`.
- `short_out` out 1: one-cycle pulse, short press completed with no second press.
- `long_out` out 1: one-cycle pulse, hold reached `LONG_CYCLES`.
- `double_out` out 1: one-cycle pulse, second press started within the gap.
- `held_out` out 1: high while the FSM is in a pressed state.
- `press_count_out` out 8: count of rising edges on `clean_in`; wraps 255 -> 0.

## Operation
- Edge detect: `prev` register; rise = `clean_in & ~prev`. `prev` resets to 0, so a `clean_in` that is high after reset counts as a press.
- Single shared counter `count`, width `$clog2(max(LONG_CYCLES, GAP_CYCLES))`. Cleared on every state entry. Saturation is never needed.
- FSM states: IDLE, PRESSED, LONG_HELD, WAIT_GAP, SECOND.
  - IDLE: on rise, go to PRESSED.
  - PRESSED, `clean_in`=0: go to WAIT_GAP. A release takes priority over long detection in the same cycle.
  - PRESSED, otherwise: if `count == LONG_CYCLES-1`, go to LONG_HELD and pulse `long_out`; else increment `count`.
  - LONG_HELD: on `clean_in`=0, go to IDLE. No `short_out` is emitted.
  - WAIT_GAP: on rise, go to SECOND and pulse `double_out`. A rise takes priority over expiry.
  - WAIT_GAP, otherwise: if `count == GAP_CYCLES-1`, go to IDLE and pulse `short_out`; else increment `count`.
  - SECOND: on `clean_in`=0, go to IDLE. Holding in SECOND never produces `long_out`.
- `held_out` = state ∈ {PRESSED, LONG_HELD, SECOND}.
- `press_count_out` increments on every detected rise, in any state.
- At most one of `short_out` / `long_out` / `double_out` is high in any cycle.
- Reset, including mid-operation, asynchronously clears all state:
  - Registers: state=IDLE, `count`=0, `prev`=0.
  - Outputs: all 0, including `press_count_out`.
  - No pending event is emitted.

## Timing
- All outputs are registered.
- Let E0 be the edge that samples a rise. State is PRESSED after E0.
- If held, `long_out` is high for the single cycle after edge E0+LONG_CYCLES.
- Let R0 be the edge that samples `clean_in`=0 in PRESSED. If no rise is sampled at edges R0+1 … R0+GAP_CYCLES, `short_out` is high for the cycle after edge R0+GAP_CYCLES.
- A rise sampled at edge Ek during WAIT_GAP gives `double_out` high for the cycle after Ek. `press_count_out` updates on the same edge.
- `held_out` follows state, so it has 1-cycle latency from the sampling edge.

## Structure
- Package `button_event_pkg`:
  - `typedef enum logic [2:0] btn_state_t` {IDLE, PRESSED, LONG_HELD, WAIT_GAP, SECOND}.
  - Constant `PRESS_CNT_W = 8`.
- Sub-module `edge_detect`: registered `prev`, outputs `rise`/`fall`, asynchronous reset to 0.
- The FSM and counter stay in `button_event`.

## Test plan
All scenarios use `LONG_CYCLES`=20 and `GAP_CYCLES`=10.
- Reset released with `clean_in`=0, idle for 50 cycles -> all outputs 0, `press_count_out`=0.
- Hold high for 5 cycles, then low for 15 -> exactly one `short_out` pulse, 10 cycles after the release edge; `press_count_out`=1; `held_out` high for 5 cycles.
- Hold high for 30 cycles -> `long_out` pulse in the cycle after edge E0+20; no `short_out` after release.
- High 3 cycles, low 4, high 3, low 15 -> `double_out` on the second rise; `press_count_out`=2; no `short_out`.
- Rise sampled exactly at edge R0+10 -> `double_out`, not `short_out`. Release sampled at the edge where `count`=19 -> no `long_out`; `short_out` follows the gap.
- Assert `rst_in` mid-PRESSED and mid-WAIT_GAP -> outputs clear immediately, no pulse after release. Perform 256 presses -> `press_count_out` wraps to 0.
